// File: rtl/vx_dcache_req_throttle_pkg.sv
`default_nettype none
// vx_dcache_req_throttle_pkg: shared types and helpers for the dcache request throttle.
// Rev 1.0
package vx_dcache_req_throttle_pkg;

  typedef enum logic [1:0] {
    DRN_RUN      = 2'd0,
    DRN_DRAINING = 2'd1,
    DRN_DRAINED  = 2'd2
  } drain_state_t;

  // Pending-counter width able to hold the value max_pending itself.
  function automatic int pend_width(input int max_pending);
    return $clog2(max_pending + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vx_req_skid_buf.sv
`default_nettype none
// vx_req_skid_buf: 2-entry valid/ready skid buffer, 1-cycle latency, full throughput.
// Rev 1.0
module vx_req_skid_buf #(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [DATAW-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  input  logic             out_ready,
  output logic             empty
);

  logic             skid_valid;
  logic [DATAW-1:0] skid_data;
  logic             out_load;

  // Ready depends only on registered state so upstream sees no combinational path.
  assign in_ready = ~skid_valid;
  assign empty    = ~out_valid & ~skid_valid;
  assign out_load = out_ready | ~out_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_load) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
      end
    end else if (in_valid) begin
      skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (out_load) begin
      out_data <= skid_valid ? skid_data : in_data;
    end else if (in_valid && !skid_valid) begin
      skid_data <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vx_dcache_req_throttle.sv
`default_nettype none
// vx_dcache_req_throttle: per-lane registered dcache requests with outstanding-read cap,
// drain handshake and perf counters.  Rev 1.0
module vx_dcache_req_throttle
  import vx_dcache_req_throttle_pkg::*;
#(
  parameter int NUM_REQS    = 4,
  parameter int ADDR_WIDTH  = 30,
  parameter int DATA_SIZE   = 4,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 16,
  parameter int CTR_BITS    = 44
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQS-1:0]               core_req_valid,
  input  logic [NUM_REQS-1:0]               core_req_rw,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]    core_req_addr,
  input  logic [NUM_REQS*DATA_SIZE-1:0]     core_req_byteen,
  input  logic [NUM_REQS*DATA_SIZE*8-1:0]   core_req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]     core_req_tag,
  output logic [NUM_REQS-1:0]               core_req_ready,
  output logic [NUM_REQS-1:0]               mem_req_valid,
  output logic [NUM_REQS-1:0]               mem_req_rw,
  output logic [NUM_REQS*ADDR_WIDTH-1:0]    mem_req_addr,
  output logic [NUM_REQS*DATA_SIZE-1:0]     mem_req_byteen,
  output logic [NUM_REQS*DATA_SIZE*8-1:0]   mem_req_data,
  output logic [NUM_REQS*TAG_WIDTH-1:0]     mem_req_tag,
  input  logic [NUM_REQS-1:0]               mem_req_ready,
  input  logic [NUM_REQS-1:0]               mem_rsp_valid,
  input  logic [NUM_REQS*DATA_SIZE*8-1:0]   mem_rsp_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]     mem_rsp_tag,
  output logic [NUM_REQS-1:0]               mem_rsp_ready,
  output logic [NUM_REQS-1:0]               core_rsp_valid,
  output logic [NUM_REQS*DATA_SIZE*8-1:0]   core_rsp_data,
  output logic [NUM_REQS*TAG_WIDTH-1:0]     core_rsp_tag,
  input  logic [NUM_REQS-1:0]               core_rsp_ready,
  input  logic                              drain_req,
  output logic                              drained,
  output logic [CTR_BITS-1:0]               perf_loads,
  output logic [CTR_BITS-1:0]               perf_stores,
  output logic [CTR_BITS-1:0]               perf_load_lat,
  output logic [CTR_BITS-1:0]               perf_throttle_stalls
);

  localparam int PEND_W = pend_width(MAX_PENDING);
  localparam int WORD_W = DATA_SIZE * 8;
  localparam int DATAW  = 1 + ADDR_WIDTH + DATA_SIZE + WORD_W + TAG_WIDTH;
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  drain_state_t                     state;
  logic [NUM_REQS-1:0]              skid_ready;
  logic [NUM_REQS-1:0]              skid_empty;
  logic [NUM_REQS-1:0]              req_fire;
  logic [NUM_REQS-1:0]              rd_fire;
  logic [NUM_REQS-1:0]              wr_fire;
  logic [NUM_REQS-1:0]              rsp_fire;
  logic [NUM_REQS-1:0]              lane_stall;
  logic [NUM_REQS-1:0]              pend_zero_nxt;
  logic [NUM_REQS-1:0][PEND_W-1:0]  pend_all;
  logic                             all_idle;
  logic [CTR_BITS-1:0]              n_loads;
  logic [CTR_BITS-1:0]              n_stores;
  logic [CTR_BITS-1:0]              lat_sum;

  // Responses bypass the throttle entirely; only reset masks them.
  assign core_rsp_valid = reset ? '0 : mem_rsp_valid;
  assign mem_rsp_ready  = reset ? '0 : core_rsp_ready;
  assign core_rsp_data  = mem_rsp_data;
  assign core_rsp_tag   = mem_rsp_tag;

  assign rd_fire  = req_fire & ~core_req_rw;
  assign wr_fire  = req_fire &  core_req_rw;
  assign rsp_fire = core_rsp_valid & core_rsp_ready;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
    logic              throttled;
    logic [PEND_W-1:0] pend;
    logic [PEND_W-1:0] pend_nxt;
    logic [DATAW-1:0]  skid_in;
    logic [DATAW-1:0]  skid_out;

    assign throttled         = ~core_req_rw[i] & (pend == PEND_MAX);
    assign core_req_ready[i] = skid_ready[i] & (state == DRN_RUN) & ~throttled;
    assign req_fire[i]       = core_req_valid[i] & core_req_ready[i];
    assign lane_stall[i]     = core_req_valid[i] & skid_ready[i] & ~core_req_ready[i];

    assign skid_in = {core_req_rw[i],
                      core_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                      core_req_byteen[i*DATA_SIZE +: DATA_SIZE],
                      core_req_data[i*WORD_W +: WORD_W],
                      core_req_tag[i*TAG_WIDTH +: TAG_WIDTH]};

    assign {mem_req_rw[i],
            mem_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
            mem_req_byteen[i*DATA_SIZE +: DATA_SIZE],
            mem_req_data[i*WORD_W +: WORD_W],
            mem_req_tag[i*TAG_WIDTH +: TAG_WIDTH]} = skid_out;

    vx_req_skid_buf #(.DATAW(DATAW)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (req_fire[i]),
      .in_data   (skid_in),
      .in_ready  (skid_ready[i]),
      .out_valid (mem_req_valid[i]),
      .out_data  (skid_out),
      .out_ready (mem_req_ready[i]),
      .empty     (skid_empty[i])
    );

    // A read fire cannot overflow: reads are refused while pend == PEND_MAX.
    always_comb begin
      pend_nxt = pend;
      if (rd_fire[i] && !rsp_fire[i]) begin
        pend_nxt = pend + PEND_W'(1);
      end else if (!rd_fire[i] && rsp_fire[i] && pend != '0) begin
        pend_nxt = pend - PEND_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) pend <= '0;
      else       pend <= pend_nxt;
    end

    assign pend_all[i]      = pend;
    assign pend_zero_nxt[i] = (pend_nxt == '0);

    a_no_rsp_underflow : assert property (@(posedge clk) disable iff (reset)
                                          !(rsp_fire[i] && pend == '0));
  end

  // Quiesce is judged on post-update counts so drained rises right after the last response.
  assign all_idle = (&pend_zero_nxt) & (&skid_empty);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= DRN_RUN;
      drained <= 1'b0;
    end else begin
      unique case (state)
        DRN_RUN: begin
          if (drain_req) state <= DRN_DRAINING;
        end
        DRN_DRAINING: begin
          if (!drain_req) begin
            state <= DRN_RUN;
          end else if (all_idle) begin
            state   <= DRN_DRAINED;
            drained <= 1'b1;
          end
        end
        DRN_DRAINED: begin
          if (!drain_req) begin
            state   <= DRN_RUN;
            drained <= 1'b0;
          end
        end
        default: begin
          state   <= DRN_RUN;
          drained <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    n_loads  = '0;
    n_stores = '0;
    lat_sum  = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      n_loads  = n_loads  + CTR_BITS'(rd_fire[i]);
      n_stores = n_stores + CTR_BITS'(wr_fire[i]);
      lat_sum  = lat_sum  + CTR_BITS'(pend_all[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_loads           <= '0;
      perf_stores          <= '0;
      perf_load_lat        <= '0;
      perf_throttle_stalls <= '0;
    end else begin
      perf_loads    <= perf_loads + n_loads;
      perf_stores   <= perf_stores + n_stores;
      perf_load_lat <= perf_load_lat + lat_sum;
      if (|lane_stall) perf_throttle_stalls <= perf_throttle_stalls + CTR_BITS'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vx_dcache_req_throttle.sv
`default_nettype none
// tb_vx_dcache_req_throttle: scoreboard bench for the dcache request throttle (MAX_PENDING=4).
// Rev 1.0
module tb_vx_dcache_req_throttle;

  localparam int NR = 4;
  localparam int AW = 30;
  localparam int DS = 4;
  localparam int TW = 8;
  localparam int MP = 4;
  localparam int CB = 44;
  localparam int WW = DS * 8;

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DS-1:0] byteen;
    logic [WW-1:0] data;
    logic [TW-1:0] tag;
  } req_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     core_req_valid, core_req_rw, core_req_ready;
  logic [NR*AW-1:0]  core_req_addr, mem_req_addr;
  logic [NR*DS-1:0]  core_req_byteen, mem_req_byteen;
  logic [NR*WW-1:0]  core_req_data, mem_req_data, mem_rsp_data, core_rsp_data;
  logic [NR*TW-1:0]  core_req_tag, mem_req_tag, mem_rsp_tag, core_rsp_tag;
  logic [NR-1:0]     mem_req_valid, mem_req_rw, mem_req_ready;
  logic [NR-1:0]     mem_rsp_valid, mem_rsp_ready, core_rsp_valid, core_rsp_ready;
  logic              drain_req, drained;
  logic [CB-1:0]     perf_loads, perf_stores, perf_load_lat, perf_throttle_stalls;

  int compared   = 0;
  int mismatched = 0;
  req_t exp_q[NR][$];

  vx_dcache_req_throttle #(
    .NUM_REQS(NR), .ADDR_WIDTH(AW), .DATA_SIZE(DS), .TAG_WIDTH(TW),
    .MAX_PENDING(MP), .CTR_BITS(CB)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_rw(core_req_rw),
    .core_req_addr(core_req_addr), .core_req_byteen(core_req_byteen),
    .core_req_data(core_req_data), .core_req_tag(core_req_tag),
    .core_req_ready(core_req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_byteen(mem_req_byteen),
    .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
    .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data),
    .core_rsp_tag(core_rsp_tag), .core_rsp_ready(core_rsp_ready),
    .drain_req(drain_req), .drained(drained),
    .perf_loads(perf_loads), .perf_stores(perf_stores),
    .perf_load_lat(perf_load_lat), .perf_throttle_stalls(perf_throttle_stalls)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic req_t make_req(input int l, input logic rw, input logic [7:0] tag);
    req_t r;
    r.rw     = rw;
    r.addr   = {22'(l), tag};
    r.byteen = 4'hF ^ 4'(l);
    r.data   = {tag, ~tag, tag ^ 8'h5A, 8'(l)};
    r.tag    = tag;
    return r;
  endfunction

  task automatic drive(input int l, input logic v, input logic rw, input logic [7:0] tag);
    req_t r;
    r = make_req(l, rw, tag);
    core_req_valid[l]             = v;
    core_req_rw[l]                = rw;
    core_req_addr[l*AW +: AW]     = r.addr;
    core_req_byteen[l*DS +: DS]   = r.byteen;
    core_req_data[l*WW +: WW]     = r.data;
    core_req_tag[l*TW +: TW]      = r.tag;
  endtask

  // Called at a negedge: records the request the DUT is about to accept.
  task automatic push_if_fired(input int l, input logic rw, input logic [7:0] tag);
    if (core_req_valid[l] && core_req_ready[l]) exp_q[l].push_back(make_req(l, rw, tag));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted mem request must match the oldest expected one on its lane.
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (mem_req_valid[i] && mem_req_ready[i]) begin
        if (exp_q[i].size() == 0) begin
          check($sformatf("unexpected_req_l%0d", i), 128'(mem_req_tag[i*TW +: TW]), 128'hDEAD);
        end else begin
          req_t got, exp;
          got = {mem_req_rw[i], mem_req_addr[i*AW +: AW], mem_req_byteen[i*DS +: DS],
                 mem_req_data[i*WW +: WW], mem_req_tag[i*TW +: TW]};
          exp = exp_q[i].pop_front();
          check($sformatf("mem_req_l%0d", i), 128'(got), 128'(exp));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit got_it;
    reset = 1'b1;
    core_req_valid = '0; core_req_rw = '0; core_req_addr = '0; core_req_byteen = '0;
    core_req_data = '0; core_req_tag = '0;
    mem_req_ready = '1; mem_rsp_valid = '1; core_rsp_ready = '1;
    mem_rsp_data = '0; mem_rsp_tag = '0; drain_req = 1'b0;
    repeat (3) tick();

    @(negedge clk);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_core_rsp_valid", core_rsp_valid, 0);
    check("rst_mem_rsp_ready", mem_rsp_ready, 0);
    check("rst_drained", drained, 0);
    check("rst_perf", {perf_loads, perf_stores, perf_load_lat, perf_throttle_stalls}, 0);
    tick();
    reset = 1'b0; mem_rsp_valid = '0; core_rsp_ready = '0;
    tick();

    // Back-to-back reads on every lane; output appears one cycle after acceptance.
    for (int k = 0; k < 4; k++) begin
      for (int l = 0; l < NR; l++) drive(l, 1'b1, 1'b0, 8'(l * 16 + k));
      @(negedge clk);
      check($sformatf("b2b_ready_%0d", k), core_req_ready, 4'hF);
      check($sformatf("b2b_mem_valid_%0d", k), mem_req_valid, (k == 0) ? 4'h0 : 4'hF);
      for (int l = 0; l < NR; l++) push_if_fired(l, 1'b0, 8'(l * 16 + k));
      tick();
    end
    core_req_valid = '0;

    // All lanes at MAX pending: a fifth read on lane0 is throttled.
    drive(0, 1'b1, 1'b0, 8'h04);
    @(negedge clk);
    check("thr_ready0_full", core_req_ready[0], 0);
    check("thr_mem_valid_last", mem_req_valid, 4'hF);
    check("thr_loads16", perf_loads, 16);
    check("thr_lat24", perf_load_lat, 24);
    check("thr_stalls0", perf_throttle_stalls, 0);
    tick();
    mem_rsp_valid[0] = 1'b1; core_rsp_ready[0] = 1'b1;
    mem_rsp_tag[7:0] = 8'h00; mem_rsp_data[31:0] = 32'hCAFE0000;
    @(negedge clk);
    check("thr_ready0_still", core_req_ready[0], 0);
    check("rsp_pass_valid", core_rsp_valid, 4'b0001);
    check("rsp_pass_ready", mem_rsp_ready, 4'b0001);
    check("rsp_pass_data", core_rsp_data[31:0], 32'hCAFE0000);
    check("thr_stalls1", perf_throttle_stalls, 1);
    tick();
    mem_rsp_valid[0] = 1'b0;
    @(negedge clk);
    check("thr_ready0_after_rsp", core_req_ready[0], 1);
    check("thr_stalls2", perf_throttle_stalls, 2);
    check("thr_lat56", perf_load_lat, 56);
    push_if_fired(0, 1'b0, 8'h04);
    tick();

    // Read fire and response fire in the same cycle leave the count unchanged.
    core_req_valid = '0;
    mem_rsp_valid[0] = 1'b1;
    @(negedge clk);
    check("same_loads17", perf_loads, 17);
    check("same_lat71", perf_load_lat, 71);
    tick();
    drive(0, 1'b1, 1'b0, 8'h05);
    @(negedge clk);
    check("same_ready0", core_req_ready[0], 1);
    push_if_fired(0, 1'b0, 8'h05);
    tick();
    core_req_valid = '0; mem_rsp_valid = '0;
    @(negedge clk);
    check("same_ready0_kept", core_req_ready[0], 1);
    check("same_loads18", perf_loads, 18);
    check("same_lat102", perf_load_lat, 102);
    tick();
    drain_req = 1'b1;
    @(negedge clk);
    check("same_lat117", perf_load_lat, 117);
    tick();

    // Drain: requests blocked, responses still flow, drained after the last one.
    core_rsp_ready = '1;
    for (int k = 0; k < 4; k++) begin
      mem_rsp_valid = (k < 3) ? 4'hF : 4'hE;
      mem_rsp_tag   = {4{8'(8'h80 + k)}};
      @(negedge clk);
      if (k == 0) check("drn_ready_blocked", core_req_ready, 0);
      check($sformatf("drn_rsp_tag_%0d", k), core_rsp_tag, {4{8'(8'h80 + k)}});
      check($sformatf("drn_not_yet_%0d", k), drained, 0);
      tick();
    end
    mem_rsp_valid = '0; core_rsp_ready = '0; drain_req = 1'b0;
    @(negedge clk);
    check("drn_drained", drained, 1);
    check("drn_lat168", perf_load_lat, 168);
    tick();
    @(negedge clk);
    check("drn_released", drained, 0);
    check("drn_ready_back", core_req_ready, 4'hF);
    tick();

    // Writes only on lane1: never throttled, never counted as pending.
    for (int k = 0; k < 20; k++) begin
      drive(1, 1'b1, 1'b1, 8'(8'h20 + k));
      @(negedge clk);
      check($sformatf("wr_ready_%0d", k), core_req_ready[1], 1);
      push_if_fired(1, 1'b1, 8'(8'h20 + k));
      tick();
    end
    core_req_valid = '0;
    @(negedge clk);
    check("wr_stores20", perf_stores, 20);
    check("wr_loads18", perf_loads, 18);
    check("wr_lat_flat", perf_load_lat, 168);
    tick();

    // Cache backpressure on lane2: two entries buffered, third waits without a throttle stall.
    mem_req_ready = 4'b1011;
    for (int k = 0; k < 2; k++) begin
      drive(2, 1'b1, 1'b1, 8'(8'h40 + k));
      @(negedge clk);
      check($sformatf("bp_ready_%0d", k), core_req_ready[2], 1);
      push_if_fired(2, 1'b1, 8'(8'h40 + k));
      tick();
    end
    drive(2, 1'b1, 1'b1, 8'h42);
    @(negedge clk);
    check("bp_full", core_req_ready[2], 0);
    tick();
    mem_req_ready = 4'hF;
    got_it = 1'b0;
    for (int t = 0; t < 10 && !got_it; t++) begin
      @(negedge clk);
      if (core_req_ready[2]) begin
        push_if_fired(2, 1'b1, 8'h42);
        got_it = 1'b1;
      end
      tick();
    end
    check("bp_accept_timeout", got_it, 1);
    core_req_valid = '0;
    @(negedge clk);
    check("bp_stores23", perf_stores, 23);
    check("bp_stalls2", perf_throttle_stalls, 2);
    tick();

    // Reset in the middle of traffic with two reads outstanding on lane3.
    for (int k = 0; k < 2; k++) begin
      drive(3, 1'b1, 1'b0, 8'(8'h50 + k));
      @(negedge clk);
      push_if_fired(3, 1'b0, 8'(8'h50 + k));
      tick();
    end
    core_req_valid = '0;
    @(negedge clk);
    tick();
    reset = 1'b1;
    drive(0, 1'b1, 1'b0, 8'h60);
    mem_rsp_valid = 4'b1000; core_rsp_ready = '1;
    @(negedge clk);
    check("mrst_rsp_masked", core_rsp_valid, 0);
    tick();
    @(negedge clk);
    check("mrst_mem_req_valid", mem_req_valid, 0);
    check("mrst_core_rsp_valid", core_rsp_valid, 0);
    check("mrst_mem_rsp_ready", mem_rsp_ready, 0);
    check("mrst_drained", drained, 0);
    check("mrst_perf", {perf_loads, perf_stores, perf_load_lat, perf_throttle_stalls}, 0);
    tick();
    reset = 1'b0; core_req_valid = '0; mem_rsp_valid = '0; core_rsp_ready = '0;
    tick();
    tick();
    @(negedge clk);
    check("post_rst_lat0", perf_load_lat, 0);
    check("post_rst_ready", core_req_ready, 4'hF);

    for (int l = 0; l < NR; l++) check($sformatf("queue_empty_l%0d", l), exp_q[l].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
